// File: rtl/diff_power_meter.sv
// Differential power detector: forms d = p - n per sample pair and reports
// mean(d^2) and max|d| over windows of 2^LOG2N samples via a valid/ready register.
module diff_power_meter #(
  parameter int DW    = 12,
  parameter int LOG2N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_p,
  input  logic signed [DW-1:0] in_n,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [2*DW:0]        out_power,
  output logic [DW:0]          out_peak,
  output logic                 overrun
);

  localparam int SW = 2*DW + 1;
  localparam int AW = SW + LOG2N;

  function automatic logic [DW:0] abs_d(input logic signed [DW:0] d);
    logic signed [DW:0] neg;
    neg = -d;
    return d[DW] ? $unsigned(neg) : $unsigned(d);
  endfunction

  function automatic logic [DW:0] max_u(input logic [DW:0] a, input logic [DW:0] b);
    return (a > b) ? a : b;
  endfunction

  logic signed [DW:0]     w_d;
  logic signed [DW:0]     r_d_p1;
  logic                   r_vld_p1;
  logic signed [2*DW+1:0] w_ext;
  logic signed [2*DW+1:0] w_prod;
  logic [SW-1:0]          r_sq_p2;
  logic [DW:0]            r_abs_p2;
  logic                   r_vld_p2;
  logic [AW-1:0]          r_acc;
  logic [DW:0]            r_pk;
  logic [LOG2N-1:0]       r_cnt;
  logic [AW-1:0]          w_sum;
  logic [DW:0]            w_pk_next;
  logic [SW-1:0]          w_result;
  logic                   w_close;

  // One extra bit makes the leg difference exact.
  assign w_d = {in_p[DW-1], in_p} - {in_n[DW-1], in_n};

  // Stage 1: differential sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_d_p1   <= '0;
    end else if (clr) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) r_d_p1 <= w_d;
    end
  end

  assign w_ext  = {{(DW+1){r_d_p1[DW]}}, r_d_p1};
  assign w_prod = w_ext * w_ext;

  // Stage 2: square and magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_sq_p2  <= '0;
      r_abs_p2 <= '0;
    end else if (clr) begin
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sq_p2  <= w_prod[SW-1:0];
        r_abs_p2 <= abs_d(r_d_p1);
      end
    end
  end

  assign w_sum     = r_acc + {{LOG2N{1'b0}}, r_sq_p2};
  assign w_pk_next = max_u(r_pk, r_abs_p2);
  assign w_result  = w_sum[AW-1:LOG2N];
  assign w_close   = r_vld_p2 & (&r_cnt);

  // Stage 3: window accumulation; a closing sample restarts the window in the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_pk  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_pk  <= '0;
      r_cnt <= '0;
    end else if (r_vld_p2) begin
      if (w_close) begin
        r_acc <= '0;
        r_pk  <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_pk  <= w_pk_next;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Result register: a full, undrained register keeps its data and flags the loss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_power <= '0;
      out_peak  <= '0;
      overrun   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (w_close) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_power <= w_result;
        out_peak  <= w_pk_next;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_power_meter.sv
// Bench for diff_power_meter: two instances (N=4 and N=2) share the sample stream
// and are checked every cycle against a window-level model plus literal expectations.
module tb_diff_power_meter;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, clr, in_valid, rdy4, rdy2;
  logic signed [DW-1:0] in_p, in_n;
  logic                 v4, v2, ov4, ov2;
  logic [2*DW:0]        pw4, pw2;
  logic [DW:0]          pk4, pk2;

  diff_power_meter #(.DW(DW), .LOG2N(2)) u_n4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_p(in_p), .in_n(in_n),
    .out_ready(rdy4), .out_valid(v4), .out_power(pw4), .out_peak(pk4), .overrun(ov4));

  diff_power_meter #(.DW(DW), .LOG2N(1)) u_n2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_p(in_p), .in_n(in_n),
    .out_ready(rdy2), .out_valid(v2), .out_power(pw2), .out_peak(pk2), .overrun(ov2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model state, index 0 = N=4 instance, index 1 = N=2 instance.
  longint m_sum[2];
  int     m_cnt[2];
  int     m_max[2];
  bit     m_val[2];
  bit     m_ov[2];
  longint m_pw[2];
  int     m_pk[2];
  // Results scheduled to reach the output register at edge number (slot mod 4).
  bit     s_v[2][4];
  longint s_pw[2][4];
  int     s_pk[2][4];
  int     ecnt = 0;

  initial begin : model_proc
    int d, ad, lg, s;
    bit rdy;
    forever begin
      @(posedge clk);
      d  = int'(in_p) - int'(in_n);
      ad = (d < 0) ? -d : d;
      s  = ecnt % 4;
      for (int i = 0; i < 2; i++) begin
        lg  = (i == 0) ? 2 : 1;
        rdy = (i == 0) ? rdy4 : rdy2;
        if (!rst_n || clr) begin
          m_sum[i] = 0; m_cnt[i] = 0; m_max[i] = 0;
          m_val[i] = 0; m_ov[i] = 0;
          for (int k = 0; k < 4; k++) s_v[i][k] = 0;
          if (!rst_n) begin
            m_pw[i] = 0; m_pk[i] = 0;
          end
        end else begin
          if (s_v[i][s]) begin
            if (!m_val[i] || rdy) begin
              m_val[i] = 1; m_pw[i] = s_pw[i][s]; m_pk[i] = s_pk[i][s];
            end else begin
              m_ov[i] = 1;
            end
          end else if (m_val[i] && rdy) begin
            m_val[i] = 0;
          end
          s_v[i][s] = 0;
          if (in_valid) begin
            m_sum[i] += longint'(d) * d;
            if (ad > m_max[i]) m_max[i] = ad;
            m_cnt[i]++;
            if (m_cnt[i] == (1 << lg)) begin
              s_v[i][(ecnt + 2) % 4]  = 1;
              s_pw[i][(ecnt + 2) % 4] = m_sum[i] >> lg;
              s_pk[i][(ecnt + 2) % 4] = m_max[i];
              m_sum[i] = 0; m_cnt[i] = 0; m_max[i] = 0;
            end
          end
        end
      end
      ecnt++;
    end
  end

  initial begin : cmp_proc
    forever begin
      @(negedge clk);
      chk("n4.out_valid", v4, m_val[0]);
      chk("n4.overrun", ov4, m_ov[0]);
      if (m_val[0]) begin
        chk("n4.out_power", pw4, m_pw[0]);
        chk("n4.out_peak", pk4, m_pk[0]);
      end
      chk("n2.out_valid", v2, m_val[1]);
      chk("n2.overrun", ov2, m_ov[1]);
      if (m_val[1]) begin
        chk("n2.out_power", pw2, m_pw[1]);
        chk("n2.out_peak", pk2, m_pk[1]);
      end
    end
  end

  task automatic cyc(input logic v, input int p, input int n);
    in_valid = v;
    in_p     = DW'(p);
    in_n     = DW'(n);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    for (int j = 0; j < k; j++) @(negedge clk);
  endtask

  // Called right after the last sample of a window has been captured.
  task automatic expect_win(input bit n2, input longint pw, input int pk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_valid_early", n2 ? v2 : v4, 0);
    @(negedge clk);
    chk("lit_valid", n2 ? v2 : v4, 1);
    chk("lit_power", n2 ? pw2 : pw4, pw);
    chk("lit_peak", n2 ? pk2 : pk4, pk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin : driver
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_p = '0; in_n = '0;
    rdy4 = 1'b1; rdy2 = 1'b1;
    @(negedge clk);
    chk("rst_valid", v4, 0);
    chk("rst_power", pw4, 0);
    chk("rst_peak", pk4, 0);
    chk("rst_overrun", ov4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady state: 100 - (-100) = 200
    repeat (4) cyc(1, 100, -100);
    expect_win(0, 40000, 200);

    // Extremes: d = -4095
    repeat (4) cyc(1, -2048, 2047);
    expect_win(0, 16769025, 4095);

    // Mixed with gaps: d = 3, 0, -5, 1
    cyc(1, 3, 0);   idle($urandom_range(1, 3));
    cyc(1, 0, 0);   idle($urandom_range(1, 3));
    cyc(1, -5, 0);  idle($urandom_range(1, 3));
    cyc(1, 1, 0);
    expect_win(0, 8, 5);

    // Backpressure on the N=2 instance
    idle(2);
    rdy2 = 1'b0;
    repeat (2) cyc(1, 2, 0);
    repeat (2) cyc(1, 4, 0);
    idle(3);
    chk("bp_valid", v2, 1);
    chk("bp_power_held", pw2, 4);
    chk("bp_peak_held", pk2, 2);
    chk("bp_overrun", ov2, 1);
    rdy2 = 1'b1;
    idle(1);
    rdy2 = 1'b0;
    chk("bp_drained", v2, 0);
    chk("bp_overrun_sticky", ov2, 1);
    repeat (2) cyc(1, 6, 0);
    expect_win(1, 36, 6);
    chk("bp_overrun_still", ov2, 1);

    // Simultaneous close and drain
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("clr_valid", v2, 0);
    chk("clr_overrun", ov2, 0);
    repeat (2) cyc(1, 1, 0);
    expect_win(1, 1, 1);
    repeat (2) cyc(1, 3, 0);
    idle(1);
    chk("sd_old_power", pw2, 1);
    rdy2 = 1'b1;
    idle(1);
    rdy2 = 1'b0;
    chk("sd_valid", v2, 1);
    chk("sd_power", pw2, 9);
    chk("sd_peak", pk2, 3);
    chk("sd_overrun", ov2, 0);
    rdy2 = 1'b1;

    // Clear mid-window together with a valid sample
    repeat (2) cyc(1, 7, 0);
    clr = 1'b1;
    cyc(1, 9, 0);
    clr = 1'b0;
    chk("mclr_valid", v4, 0);
    chk("mclr_overrun", ov4, 0);
    repeat (4) cyc(1, 10, 0);
    expect_win(0, 100, 10);

    // Asynchronous reset mid-window
    repeat (2) cyc(1, 7, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("arst_valid", v4, 0);
    chk("arst_power", pw4, 0);
    chk("arst_peak", pk4, 0);
    #2 rst_n = 1'b1;
    repeat (4) cyc(1, 10, 0);
    expect_win(0, 100, 10);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
